// File: rtl/seq_mode_checker.sv
// rtl/seq_mode_checker.sv - receive-side lock/error checker for the 4-word mode sequence stream
// Hunts for a unique table word, verifies in-order words up to lock, then flags and counts breaks.
module seq_mode_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       seq_in,
  input  logic             vld,
  output logic             locked,
  output logic             mode,
  output logic [1:0]       phase,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;

  function automatic logic [3:0] tword(input logic m, input logic [1:0] p);
    case ({m, p})
      3'b000:  tword = 4'b1000;
      3'b001:  tword = 4'b1001;
      3'b010:  tword = 4'b1010;
      3'b011:  tword = 4'b1100;
      3'b100:  tword = 4'b0011;
      3'b101:  tword = 4'b0110;
      3'b110:  tword = 4'b0101;
      default: tword = 4'b1010;
    endcase
  endfunction

  logic       hit0, hit1, match;
  logic [1:0] ph0, ph1;

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    ph0  = 2'd0;
    ph1  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (tword(1'b0, 2'(i)) == seq_in) begin
        hit0 = 1'b1;
        ph0  = 2'(i);
      end
      if (tword(1'b1, 2'(i)) == seq_in) begin
        hit1 = 1'b1;
        ph1  = 2'(i);
      end
    end
    match = (seq_in == tword(mode, phase + 2'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      locked    <= 1'b0;
      mode      <= 1'b0;
      phase     <= 2'd0;
      err       <= 1'b0;
      err_count <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (vld) begin
        case (state)
          HUNT: begin
            // A word found in both tables (1010) cannot pick a mode, so it is dropped.
            if (hit0 ^ hit1) begin
              mode      <= hit1;
              phase     <= hit1 ? ph1 : ph0;
              match_cnt <= MW'(1);
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              phase     <= phase + 2'd1;
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == LOCK_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              state     <= HUNT;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: phase advances on every word so one bad word does not desync us.
            phase <= phase + 2'd1;
            if (match) begin
              miss_cnt <= '0;
            end else begin
              err <= 1'b1;
              if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
              if (miss_cnt == LOSS_LAST) begin
                state     <= HUNT;
                locked    <= 1'b0;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_mode_checker.sv
// tb/tb_seq_mode_checker.sv - table-driven bench for seq_mode_checker
// Second instance uses ERR_W=2 and a long loss count to exercise err_count saturation.
module tb_seq_mode_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [3:0] seq_in = 4'd0;

  logic       locked, mode, err;
  logic [1:0] phase;
  logic [7:0] err_count;
  logic       locked2, mode2, err2;
  logic [1:0] phase2, err_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_mode_checker #(.LOCK_CNT(4), .LOSS_CNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .seq_in(seq_in), .vld(vld),
    .locked(locked), .mode(mode), .phase(phase), .err(err), .err_count(err_count)
  );

  seq_mode_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .seq_in(seq_in), .vld(vld),
    .locked(locked2), .mode(mode2), .phase(phase2), .err(err2), .err_count(err_count2)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] w;
    logic       locked;
    logic       mode;
    logic [1:0] phase;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [3:0] w, input logic l,
                     input logic m, input logic [1:0] p, input logic e, input logic [7:0] c);
    vec_t t;
    t.r = r; t.v = v; t.w = w; t.locked = l; t.mode = m; t.phase = p; t.err = e; t.cnt = c;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic [3:0] w);
    rst = r; vld = v; seq_in = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    add(1,1,4'b0011, 0,0,0,0,0);
    // lock on mode0 with vld gaps
    add(0,1,4'b1000, 0,0,0,0,0);
    add(0,0,4'b1111, 0,0,0,0,0);
    add(0,1,4'b1001, 0,0,1,0,0);
    add(0,0,4'b0000, 0,0,1,0,0);
    add(0,1,4'b1010, 0,0,2,0,0);
    add(0,1,4'b1100, 1,0,3,0,0);
    // single error while locked, then in-order 1010 accepted
    add(0,1,4'b1000, 1,0,0,0,0);
    add(0,1,4'b0000, 1,0,1,1,1);
    add(0,0,4'b1010, 1,0,1,0,1);
    add(0,1,4'b1010, 1,0,2,0,1);
    // two consecutive errors drop lock, then relock
    add(0,1,4'b0000, 1,0,3,1,2);
    add(0,1,4'b0000, 0,0,0,1,3);
    add(0,1,4'b1100, 0,0,3,0,3);
    add(0,1,4'b1000, 0,0,0,0,3);
    add(0,0,4'b1001, 0,0,0,0,3);
    add(0,1,4'b1001, 0,0,1,0,3);
    add(0,1,4'b1010, 1,0,2,0,3);
    // reset, VERIFY mismatch discards the word, ambiguous 1010 ignored, lock on mode1
    add(1,0,4'b0000, 0,0,0,0,0);
    add(0,1,4'b1000, 0,0,0,0,0);
    add(0,1,4'b0011, 0,0,0,0,0);
    add(0,1,4'b1010, 0,0,0,0,0);
    add(0,1,4'b0011, 0,1,0,0,0);
    add(0,0,4'b0101, 0,1,0,0,0);
    add(0,1,4'b0110, 0,1,1,0,0);
    add(0,1,4'b0101, 0,1,2,0,0);
    add(0,1,4'b1010, 1,1,3,0,0);
    // alternate bad/good to reach err_count=5 while staying locked
    add(0,1,4'b0000, 1,1,0,1,1);
    add(0,1,4'b0110, 1,1,1,0,1);
    add(0,1,4'b0000, 1,1,2,1,2);
    add(0,1,4'b1010, 1,1,3,0,2);
    add(0,1,4'b0000, 1,1,0,1,3);
    add(0,1,4'b0110, 1,1,1,0,3);
    add(0,1,4'b0000, 1,1,2,1,4);
    add(0,1,4'b1010, 1,1,3,0,4);
    add(0,1,4'b0000, 1,1,0,1,5);
    // reset dominates vld, then HUNT accepts a fresh word
    add(1,1,4'b0011, 0,0,0,0,0);
    add(0,1,4'b0011, 0,1,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].w);
      chk("locked",    i, 32'(locked),    32'(vecs[i].locked));
      chk("mode",      i, 32'(mode),      32'(vecs[i].mode));
      chk("phase",     i, 32'(phase),     32'(vecs[i].phase));
      chk("err",       i, 32'(err),       32'(vecs[i].err));
      chk("err_count", i, 32'(err_count), 32'(vecs[i].cnt));
    end

    // ERR_W=2 saturation on the second instance
    apply(1, 0, 4'b0000);
    chk("w2_reset_cnt", 0, 32'(err_count2), 32'd0);
    apply(0, 1, 4'b1000);
    apply(0, 1, 4'b1001);
    apply(0, 1, 4'b1010);
    apply(0, 1, 4'b1100);
    chk("w2_locked", 0, 32'(locked2), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      apply(0, 1, 4'b0000);
      chk("w2_err",       k, 32'(err2),       32'd1);
      chk("w2_err_count", k, 32'(err_count2), (k > 3) ? 32'd3 : 32'(k));
      chk("w2_locked",    k, 32'(locked2),    32'd1);
    end
    apply(0, 0, 4'b0000);
    chk("w2_err_clear", 6, 32'(err2),       32'd0);
    chk("w2_cnt_hold",  6, 32'(err_count2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
